ftab_segment_r_server: RTL and testbench

Read-side responder for the `segment_r` table-lookup protocol used by the JPEG decode table operators. It accepts address tokens on the `segment_r_addr` stream, reads a DEPTH×64 table, and returns one 64-bit data token per address, in order, on the `segment_r_data` stream. The table is loaded through a side write port before or during decode. End-of-stream markers pass through in order.

---
 rtl/ftab_segment_r_server.sv | 141 ++++++++++++++
 tb/tb_ftab_segment_r_server.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ftab_segment_r_server.sv
// Read-side responder for the segment_r table-lookup stream: one DEPTH x DATA_W
// table lookup per accepted address token, returned in order through a small FIFO.
module ftab_segment_r_server #(
    parameter int DEPTH  = 256,
    parameter int IDX_W  = 8,
    parameter int DATA_W = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       segment_r_addr_d,
    input  logic              segment_r_addr_e,
    input  logic              segment_r_addr_v,
    output logic              segment_r_addr_b,
    output logic [DATA_W-1:0] segment_r_data_d,
    output logic              segment_r_data_e,
    output logic              segment_r_data_v,
    input  logic              segment_r_data_b,
    input  logic [IDX_W-1:0]  load_addr_d,
    input  logic [DATA_W-1:0] load_data_d,
    input  logic              load_v,
    output logic              err_oob
);

    localparam logic [31:0]    DEPTH_32  = 32'(DEPTH);
    localparam logic [IDX_W:0] DEPTH_IDX = (IDX_W + 1)'(DEPTH);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              e;
    } tok_t;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    logic       inflight_q, inflight_d;
    logic       infl_e_q, infl_e_d;
    logic       infl_zero_q, infl_zero_d;
    logic [1:0] occ_q, occ_d;
    logic [1:0] wr_ptr_q, wr_ptr_d;
    logic [1:0] rd_ptr_q, rd_ptr_d;
    tok_t       fifo_q [3];
    tok_t       fifo_d [3];
    logic       err_q, err_d;

    logic       accept;
    logic       addr_oob;
    logic       rd_en;
    logic [2:0] total;
    logic       load_in_range;
    tok_t       land;
    tok_t       out_tok;
    logic       out_valid;
    logic       pop;
    logic       pop_fifo;
    logic       push;

    function automatic logic [1:0] ptr_next(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign total            = {1'b0, occ_q} + {2'b00, inflight_q};
    assign segment_r_addr_b = reset || (total >= 3'd3);
    assign accept           = segment_r_addr_v && !segment_r_addr_b;
    assign addr_oob         = segment_r_addr_d >= DEPTH_32;
    assign rd_en            = accept && !segment_r_addr_e && !addr_oob;
    assign load_in_range    = {1'b0, load_addr_d} < DEPTH_IDX;

    // Table storage is never reset; a same-index load and read at one edge sees old data.
    always_ff @(posedge clock) begin
        if (load_v && load_in_range) begin
            mem[load_addr_d] <= load_data_d;
        end
        if (rd_en) begin
            rd_data_q <= mem[segment_r_addr_d[IDX_W-1:0]];
        end
    end

    // With an empty FIFO the landing read is forwarded so a token answers one cycle after accept.
    always_comb begin
        land.data = infl_zero_q ? '0 : rd_data_q;
        land.e    = infl_e_q;
        out_valid = (occ_q != 2'd0) || inflight_q;
        out_tok   = '0;
        if (occ_q != 2'd0) begin
            out_tok = fifo_q[rd_ptr_q];
        end else if (inflight_q) begin
            out_tok = land;
        end
        pop      = out_valid && !segment_r_data_b;
        pop_fifo = pop && (occ_q != 2'd0);
        push     = inflight_q && !((occ_q == 2'd0) && pop);
    end

    always_comb begin
        fifo_d      = fifo_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occ_d       = occ_q + 2'(push) - 2'(pop_fifo);
        inflight_d  = accept;
        infl_e_d    = accept && segment_r_addr_e;
        infl_zero_d = accept && (segment_r_addr_e || addr_oob);
        err_d       = err_q || (accept && !segment_r_addr_e && addr_oob);
        if (push) begin
            fifo_d[wr_ptr_q] = land;
            wr_ptr_d         = ptr_next(wr_ptr_q);
        end
        if (pop_fifo) begin
            rd_ptr_d = ptr_next(rd_ptr_q);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inflight_q  <= 1'b0;
            infl_e_q    <= 1'b0;
            infl_zero_q <= 1'b0;
            occ_q       <= 2'd0;
            wr_ptr_q    <= 2'd0;
            rd_ptr_q    <= 2'd0;
            err_q       <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            inflight_q  <= inflight_d;
            infl_e_q    <= infl_e_d;
            infl_zero_q <= infl_zero_d;
            occ_q       <= occ_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            err_q       <= err_d;
            fifo_q      <= fifo_d;
        end
    end

    assign segment_r_data_v = out_valid;
    assign segment_r_data_d = out_tok.data;
    assign segment_r_data_e = out_tok.e;
    assign err_oob          = err_q;

endmodule

// File: tb/tb_ftab_segment_r_server.sv
// Directed bench for ftab_segment_r_server: reset, latency, streaming, stall,
// out-of-range, end-of-stream ordering, load/read collision and reset retention.
module tb_ftab_segment_r_server;

    logic        clock;
    logic        reset;
    logic [31:0] segment_r_addr_d;
    logic        segment_r_addr_e;
    logic        segment_r_addr_v;
    logic        segment_r_addr_b;
    logic [63:0] segment_r_data_d;
    logic        segment_r_data_e;
    logic        segment_r_data_v;
    logic        segment_r_data_b;
    logic [7:0]  load_addr_d;
    logic [63:0] load_data_d;
    logic        load_v;
    logic        err_oob;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [63:0] got_d [$];
    logic        got_e [$];
    int          got_c [$];

    localparam logic [63:0] VAL5 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] VALA = 64'hAAAA_5555_AAAA_5555;
    localparam logic [63:0] VALB = 64'hBBBB_0000_1111_CCCC;

    ftab_segment_r_server dut (
        .clock            (clock),
        .reset            (reset),
        .segment_r_addr_d (segment_r_addr_d),
        .segment_r_addr_e (segment_r_addr_e),
        .segment_r_addr_v (segment_r_addr_v),
        .segment_r_addr_b (segment_r_addr_b),
        .segment_r_data_d (segment_r_data_d),
        .segment_r_data_e (segment_r_data_e),
        .segment_r_data_v (segment_r_data_v),
        .segment_r_data_b (segment_r_data_b),
        .load_addr_d      (load_addr_d),
        .load_data_d      (load_data_d),
        .load_v           (load_v),
        .err_oob          (err_oob)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Record every consumed response mid-cycle, with the cycle it left on.
    always @(negedge clock) begin
        if (!reset && segment_r_data_v && !segment_r_data_b) begin
            got_d.push_back(segment_r_data_d);
            got_e.push_back(segment_r_data_e);
            got_c.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        got_d.delete();
        got_e.delete();
        got_c.delete();
    endtask

    task automatic send(input logic [31:0] a, input logic e);
        segment_r_addr_v = 1'b1;
        segment_r_addr_d = a;
        segment_r_addr_e = e;
        tick();
        segment_r_addr_v = 1'b0;
        segment_r_addr_e = 1'b0;
    endtask

    initial begin
        int k;
        logic ab;
        reset            = 1'b1;
        segment_r_addr_d = '0;
        segment_r_addr_e = 1'b0;
        segment_r_addr_v = 1'b0;
        segment_r_data_b = 1'b0;
        load_addr_d      = '0;
        load_data_d      = '0;
        load_v           = 1'b0;
        #1;

        load_v      = 1'b1;
        load_addr_d = 8'd5;
        load_data_d = VAL5;
        tick();
        load_v = 1'b0;
        tick();
        check("reset_data_v", 64'(segment_r_data_v), 64'd0);
        check("reset_data_d", segment_r_data_d, 64'd0);
        check("reset_data_e", 64'(segment_r_data_e), 64'd0);
        check("reset_err", 64'(err_oob), 64'd0);
        check("reset_addr_b", 64'(segment_r_addr_b), 64'd1);

        reset = 1'b0;
        #1;
        check("post_reset_addr_b", 64'(segment_r_addr_b), 64'd0);
        send(32'd5, 1'b0);
        check("latency_v", 64'(segment_r_data_v), 64'd1);
        check("latency_d", segment_r_data_d, VAL5);
        check("latency_err", 64'(err_oob), 64'd0);
        repeat (3) tick();
        clear_log();

        for (int i = 0; i < 256; i++) begin
            load_v      = 1'b1;
            load_addr_d = 8'(i);
            load_data_d = 64'(i * 3);
            tick();
        end
        load_v = 1'b0;

        for (int i = 0; i < 16; i++) begin
            check($sformatf("stream_addr_b_%0d", i), 64'(segment_r_addr_b), 64'd0);
            segment_r_addr_v = 1'b1;
            segment_r_addr_d = 32'(i);
            tick();
        end
        segment_r_addr_v = 1'b0;
        repeat (4) tick();
        check("stream_count", 64'(got_d.size()), 64'd16);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("stream_data_%0d", i), got_d[i], 64'(i * 3));
        end
        check("stream_no_gaps", 64'(got_c[15] - got_c[0]), 64'd15);
        clear_log();

        k = 0;
        for (int c = 0; c < 30; c++) begin
            segment_r_data_b = (c >= 3 && c < 9);
            segment_r_addr_v = (k < 10);
            segment_r_addr_d = 32'(10 + k);
            if (c >= 4 && c <= 8) begin
                check($sformatf("stall_v_c%0d", c), 64'(segment_r_data_v), 64'd1);
                check($sformatf("stall_hold_c%0d", c), segment_r_data_d, 64'd36);
            end
            if (c >= 5 && c <= 8) begin
                check($sformatf("stall_addr_b_c%0d", c), 64'(segment_r_addr_b), 64'd1);
            end
            ab = segment_r_addr_b;
            tick();
            if (segment_r_addr_v && !ab) k++;
        end
        segment_r_addr_v = 1'b0;
        segment_r_data_b = 1'b0;
        check("stall_count", 64'(got_d.size()), 64'd10);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("stall_data_%0d", i), got_d[i], 64'((10 + i) * 3));
        end
        clear_log();

        send(32'd300, 1'b0);
        check("oob_err_first", 64'(err_oob), 64'd1);
        check("oob_first_d", segment_r_data_d, 64'd0);
        send(32'h1000_0007, 1'b0);
        send(32'd4, 1'b0);
        repeat (3) tick();
        check("oob_count", 64'(got_d.size()), 64'd3);
        check("oob_d0", got_d[0], 64'd0);
        check("oob_d1", got_d[1], 64'd0);
        check("oob_d2", got_d[2], 64'd12);
        check("oob_err_sticky", 64'(err_oob), 64'd1);
        clear_log();

        send(32'd1, 1'b0);
        send(32'd2, 1'b0);
        send(32'd99, 1'b1);
        send(32'd3, 1'b0);
        repeat (3) tick();
        check("eos_count", 64'(got_d.size()), 64'd4);
        check("eos_d0", got_d[0], 64'd3);
        check("eos_d1", got_d[1], 64'd6);
        check("eos_d2", got_d[2], 64'd0);
        check("eos_d3", got_d[3], 64'd9);
        check("eos_e0", 64'(got_e[0]), 64'd0);
        check("eos_e1", 64'(got_e[1]), 64'd0);
        check("eos_e2", 64'(got_e[2]), 64'd1);
        check("eos_e3", 64'(got_e[3]), 64'd0);
        clear_log();

        load_v      = 1'b1;
        load_addr_d = 8'd7;
        load_data_d = VALA;
        tick();
        load_data_d      = VALB;
        segment_r_addr_v = 1'b1;
        segment_r_addr_d = 32'd7;
        tick();
        load_v = 1'b0;
        tick();
        segment_r_addr_v = 1'b0;
        repeat (3) tick();
        check("collide_count", 64'(got_d.size()), 64'd2);
        check("collide_old", got_d[0], VALA);
        check("collide_new", got_d[1], VALB);
        clear_log();

        send(32'd8, 1'b0);
        reset = 1'b1;
        #1;
        check("rst2_err", 64'(err_oob), 64'd0);
        check("rst2_data_v", 64'(segment_r_data_v), 64'd0);
        check("rst2_addr_b", 64'(segment_r_addr_b), 64'd1);
        tick();
        reset = 1'b0;
        repeat (3) tick();
        check("rst2_dropped", 64'(got_d.size()), 64'd0);
        send(32'd5, 1'b0);
        check("rst2_retained", segment_r_data_d, 64'd15);
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
